// File: rtl/drum_mac_accumulator.sv
// drum_mac_accumulator: valid/ready frame accumulator for DRUM approximate products.
// Define DRUM_MAC_SAT_EN to clamp on overflow instead of wrapping.
module drum_mac_accumulator #(
    parameter int N      = 16,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8,
    parameter int SIGNED = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*N-1:0]     in_prod_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ACC_W-1:0]   out_acc_o,
    output logic [LEN_W-1:0]   out_count_o,
    output logic               out_ovf_o
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, oacc_q, oacc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_nx;
    logic               ovf_q, ovf_d, oovf_q, oovf_d;
    logic [ACC_W-1:0]   ext, sum, res;
    logic [ACC_W:0]     sum_w;
    logic               ovf_b, take;
    assign in_ready_o  = (state_q == ACCUM) || out_ready_i;
    assign out_valid_o = (state_q == HOLD);
    assign out_acc_o   = oacc_q;
    assign out_count_o = ocnt_q;
    assign out_ovf_o   = oovf_q;
    assign take   = in_valid_i && in_ready_o && !clr_i;
    assign ext    = (SIGNED != 0) ? ACC_W'($signed(in_prod_i)) : ACC_W'(in_prod_i);
    assign sum_w  = {1'b0, acc_q} + {1'b0, ext};
    assign sum    = sum_w[ACC_W-1:0];
    assign ovf_b  = (SIGNED != 0) ? (acc_q[ACC_W-1] == ext[ACC_W-1] && sum[ACC_W-1] != acc_q[ACC_W-1])
                                  : sum_w[ACC_W];
    assign cnt_nx = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef DRUM_MAC_SAT_EN
    // Signed clamp direction follows the sign of the incoming term.
    logic [ACC_W-1:0] sat;
    assign sat = (SIGNED != 0) ? {ext[ACC_W-1], {(ACC_W-1){~ext[ACC_W-1]}}} : {ACC_W{1'b1}};
    assign res = ovf_b ? sat : sum;
`else
    assign res = sum;
`endif
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        oacc_d  = oacc_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        if (clr_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == HOLD && out_ready_i) state_d = ACCUM;
            if (take && in_last_i) begin
                state_d = HOLD;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                oacc_d  = res;
                ocnt_d  = cnt_nx;
                oovf_d  = ovf_q | ovf_b;
            end else if (take) begin
                acc_d = res;
                cnt_d = cnt_nx;
                ovf_d = ovf_q | ovf_b;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            oacc_q  <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            oacc_q  <= oacc_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end
endmodule
